maquina_n: RTL and testbench
============================

# maquina_n

Parametrised control state machine for the FIFO switch. Generalises the five-FIFO controller to NFIFO channels with UMBRAL_W-bit thresholds. Adds registered threshold latching, reconfiguration in IDLE, ACTIVE→IDLE return after a programmable all-empty hold, a sticky per-FIFO error mask and an explicit error-clear handshake. Sits between the configuration interface and the FIFO array; its status outputs and latched thresholds drive the FIFO almost-full/almost-empty logic.

## Interface
- NFIFO, 5, number of monitored FIFOs (≥1)
- UMBRAL_W, 4, threshold width in bits (≥1)
- IDLE_HOLD, 4, consecutive all-empty cycles in ACTIVE before returning to IDLE (≥1)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- init  in  1  configuration strobe, sampled each cycle
- umbral_mf / umbral_vc / umbral_d  in  UMBRAL_W each  main-FIFO / virtual-channel / destination thresholds
- fifo_empties  in  NFIFO  per-FIFO empty flags
- fifo_errors  in  NFIFO  per-FIFO error flags (overflow/underflow)
- error_clear  in  1  software acknowledge of error condition
- init_out, idle_out, active_out, error_out  out  1 each  state indicators; exactly one high except in RESET (all low)
- umbral_mf_out / umbral_vc_out / umbral_d_out  out  UMBRAL_W each  latched thresholds
- error_mask  out  NFIFO  sticky OR of fifo_errors seen since last clear
- state  out  3  current state encoding

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5–7 illegal → RESET next cycle, indicators low.
- reset high: state←RESET; threshold regs, error_mask and hold counter ←0; all outputs 0.
- RESET → INIT unconditionally.
- INIT: if init=1 and any threshold ≠0 → latch all three thresholds, go IDLE. If init=1 and all thresholds are zero, or init=0 → stay INIT, regs unchanged.
- IDLE, in priority order:
  - fifo_errors≠0 → ERROR, error_mask |= fifo_errors.
  - else init=1 with any threshold ≠0 → re-latch thresholds, stay IDLE.
  - else fifo_empties≠all-ones → ACTIVE.
  - else stay.
- ACTIVE:
  - fifo_errors≠0 → ERROR, mask |= fifo_errors.
  - init ignored.
  - Hold counter increments each cycle fifo_empties is all-ones, resets to 0 on any non-empty. When counter would reach IDLE_HOLD → IDLE, counter←0.
  - Counter width $clog2(IDLE_HOLD+1); saturates, never wraps.
- ERROR: mask |= fifo_errors every cycle. Exits to RESET when error_clear=1 and fifo_errors=0 in the same cycle. Entering RESET clears thresholds and mask. error_clear with errors still present is ignored; error_clear outside ERROR has no effect.
- Thresholds hold their value in every state except RESET and the latch events above.

## Timing
- All outputs registered or decoded directly from flops; no input→output combinational paths.
- Condition sampled at edge k → new state and indicators visible after edge k (1-cycle latency).
- Threshold latch: umbral_*_out valid the cycle IDLE is first indicated.
- ACTIVE→IDLE: first all-empty cycle sampled at edge k → idle_out high after edge k+IDLE_HOLD-1, provided no non-empty or error intervenes.
- Error beats every other event in the same cycle, including a simultaneous hold-counter expiry.
- reset overrides everything, including mid-transition; the cycle after reset deasserts, state=RESET and it moves to INIT one cycle later.

## Structure
- Package maquina_pkg: state localparams (RESET..ERROR) and the 3-bit state width constant; shared with the FIFO/bench code.
- Sub-module idle_timer: saturating counter parametrised by IDLE_HOLD, inputs clk/reset/clr/inc, output done.

## Test plan
- Reset and config: reset 2 cycles, then init=1 with umbral_mf=3, others 0 → INIT then IDLE; umbral_mf_out=3, others 0, idle_out=1.
- Zero config: init=1 with all thresholds 0 for 5 cycles → stays INIT, init_out=1, outputs 0.
- Activity and return: IDLE_HOLD=4; fifo_empties=5'b11110 one cycle → ACTIVE. Then all-ones → idle_out rises exactly 4 edges later. Same test with one non-empty cycle at count 3 → counter restarts.
- Error capture: in ACTIVE, fifo_errors=5'b00100 then 5'b01000 → ERROR, error_mask=5'b01100. error_clear=1 with errors still 5'b01000 → stays ERROR. Errors 0 with clear=1 → RESET, mask 0, thresholds 0.
- Reconfiguration: in IDLE, init=1 with umbral_vc=7 → umbral_vc_out=7, state IDLE. Same in ACTIVE → ignored.
- Simultaneous and mid-reset: error and hold expiry in the same cycle → ERROR. Reset asserted in ACTIVE → all outputs 0 next cycle.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared state encoding for the FIFO-switch control machine.
package maquina_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
    localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// Saturating all-empty hold counter; done flags the cycle the count would reach IDLE_HOLD.
module idle_timer #(
    parameter int unsigned IDLE_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(IDLE_HOLD + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_HOLD - 1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(IDLE_HOLD);

    logic [CNT_W-1:0] count;

    assign done = inc && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (done) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/maquina_n.sv
// Control FSM for the NFIFO switch: threshold latching, activity tracking,
// sticky error capture and software error-clear handshake.
module maquina_n
    import maquina_pkg::*;
#(
    parameter int unsigned NFIFO     = 5,
    parameter int unsigned UMBRAL_W  = 4,
    parameter int unsigned IDLE_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_mf,
    input  logic [UMBRAL_W-1:0] umbral_vc,
    input  logic [UMBRAL_W-1:0] umbral_d,
    input  logic [NFIFO-1:0]    fifo_empties,
    input  logic [NFIFO-1:0]    fifo_errors,
    input  logic                error_clear,
    output logic                init_out,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out,
    output logic [UMBRAL_W-1:0] umbral_mf_out,
    output logic [UMBRAL_W-1:0] umbral_vc_out,
    output logic [UMBRAL_W-1:0] umbral_d_out,
    output logic [NFIFO-1:0]    error_mask,
    output logic [STATE_W-1:0]  state
);

    localparam logic [NFIFO-1:0] ALL_EMPTY = '1;

    state_t cur;
    state_t nxt;
    logic   latch_en;
    logic   clear_regs;
    logic   mask_or;
    logic   timer_inc;
    logic   timer_clr;
    logic   timer_done;
    logic   any_thr;
    logic   any_err;
    logic   all_empty;

    assign cur       = state_t'(state);
    assign any_thr   = |{umbral_mf, umbral_vc, umbral_d};
    assign any_err   = |fifo_errors;
    assign all_empty = (fifo_empties == ALL_EMPTY);
    assign timer_clr = !timer_inc;

    idle_timer #(
        .IDLE_HOLD (IDLE_HOLD)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .inc   (timer_inc),
        .done  (timer_done)
    );

    // Next-state and register-update decode; errors take priority in IDLE/ACTIVE.
    always_comb begin
        nxt        = S_RESET;
        latch_en   = 1'b0;
        clear_regs = 1'b0;
        mask_or    = 1'b0;
        timer_inc  = 1'b0;
        case (cur)
            S_RESET: begin
                nxt        = S_INIT;
                clear_regs = 1'b1;
            end
            S_INIT: begin
                nxt = S_INIT;
                if (init && any_thr) begin
                    latch_en = 1'b1;
                    nxt      = S_IDLE;
                end
            end
            S_IDLE: begin
                nxt = S_IDLE;
                if (any_err) begin
                    nxt     = S_ERROR;
                    mask_or = 1'b1;
                end else if (init && any_thr) begin
                    latch_en = 1'b1;
                end else if (!all_empty) begin
                    nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                nxt = S_ACTIVE;
                if (any_err) begin
                    nxt     = S_ERROR;
                    mask_or = 1'b1;
                end else if (all_empty) begin
                    timer_inc = 1'b1;
                    if (timer_done) begin
                        nxt = S_IDLE;
                    end
                end
            end
            S_ERROR: begin
                nxt     = S_ERROR;
                mask_or = 1'b1;
                if (error_clear && !any_err) begin
                    nxt        = S_RESET;
                    clear_regs = 1'b1;
                end
            end
            default: begin
                nxt        = S_RESET;
                clear_regs = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RESET;
            umbral_mf_out <= '0;
            umbral_vc_out <= '0;
            umbral_d_out  <= '0;
            error_mask    <= '0;
            init_out      <= 1'b0;
            idle_out      <= 1'b0;
            active_out    <= 1'b0;
            error_out     <= 1'b0;
        end else begin
            state      <= nxt;
            init_out   <= (nxt == S_INIT);
            idle_out   <= (nxt == S_IDLE);
            active_out <= (nxt == S_ACTIVE);
            error_out  <= (nxt == S_ERROR);
            if (clear_regs) begin
                umbral_mf_out <= '0;
                umbral_vc_out <= '0;
                umbral_d_out  <= '0;
                error_mask    <= '0;
            end else begin
                if (latch_en) begin
                    umbral_mf_out <= umbral_mf;
                    umbral_vc_out <= umbral_vc;
                    umbral_d_out  <= umbral_d;
                end
                if (mask_or) begin
                    error_mask <= error_mask | fifo_errors;
                end
            end
        end
    end

endmodule

// File: tb/tb_maquina_n.sv
// Self-checking bench for maquina_n: mode-level reference model plus directed scenarios.
module tb_maquina_n;

    localparam int unsigned NFIFO     = 5;
    localparam int unsigned UMBRAL_W  = 4;
    localparam int unsigned IDLE_HOLD = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                init = 1'b0;
    logic [UMBRAL_W-1:0] umbral_mf = '0;
    logic [UMBRAL_W-1:0] umbral_vc = '0;
    logic [UMBRAL_W-1:0] umbral_d = '0;
    logic [NFIFO-1:0]    fifo_empties = '1;
    logic [NFIFO-1:0]    fifo_errors = '0;
    logic                error_clear = 1'b0;
    logic                init_out;
    logic                idle_out;
    logic                active_out;
    logic                error_out;
    logic [UMBRAL_W-1:0] umbral_mf_out;
    logic [UMBRAL_W-1:0] umbral_vc_out;
    logic [UMBRAL_W-1:0] umbral_d_out;
    logic [NFIFO-1:0]    error_mask;
    logic [2:0]          state;

    int n_cmp = 0;
    int n_bad = 0;

    maquina_n #(
        .NFIFO     (NFIFO),
        .UMBRAL_W  (UMBRAL_W),
        .IDLE_HOLD (IDLE_HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_mf     (umbral_mf),
        .umbral_vc     (umbral_vc),
        .umbral_d      (umbral_d),
        .fifo_empties  (fifo_empties),
        .fifo_errors   (fifo_errors),
        .error_clear   (error_clear),
        .init_out      (init_out),
        .idle_out      (idle_out),
        .active_out    (active_out),
        .error_out     (error_out),
        .umbral_mf_out (umbral_mf_out),
        .umbral_vc_out (umbral_vc_out),
        .umbral_d_out  (umbral_d_out),
        .error_mask    (error_mask),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: mode 0..4 = RESET, INIT, IDLE, ACTIVE, ERROR; run = consecutive all-empty cycles.
    int                  m_mode = 0;
    int                  m_run = 0;
    logic [UMBRAL_W-1:0] m_mf = '0, m_vc = '0, m_d = '0;
    logic [NFIFO-1:0]    m_mask = '0;
    bit                  started = 1'b0;

    always @(posedge clk) begin
        bit cfg_ok;
        bit errs;
        bit empty_all;
        cfg_ok    = init && ((umbral_mf != 0) || (umbral_vc != 0) || (umbral_d != 0));
        errs      = (fifo_errors != 0);
        empty_all = (fifo_empties == {NFIFO{1'b1}});
        if (reset) begin
            m_mode = 0; m_run = 0; m_mf = 0; m_vc = 0; m_d = 0; m_mask = 0;
            started = 1'b1;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (cfg_ok) begin
                       m_mf = umbral_mf; m_vc = umbral_vc; m_d = umbral_d; m_mode = 2;
                   end
                2: if (errs) begin
                       m_mask = m_mask | fifo_errors; m_mode = 4;
                   end else if (cfg_ok) begin
                       m_mf = umbral_mf; m_vc = umbral_vc; m_d = umbral_d;
                   end else if (!empty_all) begin
                       m_mode = 3; m_run = 0;
                   end
                3: if (errs) begin
                       m_mask = m_mask | fifo_errors; m_mode = 4; m_run = 0;
                   end else if (empty_all) begin
                       m_run++;
                       if (m_run == IDLE_HOLD) begin
                           m_mode = 2; m_run = 0;
                       end
                   end else begin
                       m_run = 0;
                   end
                default: begin
                    m_mask = m_mask | fifo_errors;
                    if (error_clear && !errs) begin
                        m_mode = 0; m_mf = 0; m_vc = 0; m_d = 0; m_mask = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_state",  32'(state),         32'(m_mode));
            check("m_init",   32'(init_out),      32'(m_mode == 1));
            check("m_idle",   32'(idle_out),      32'(m_mode == 2));
            check("m_active", 32'(active_out),    32'(m_mode == 3));
            check("m_error",  32'(error_out),     32'(m_mode == 4));
            check("m_mf",     32'(umbral_mf_out), 32'(m_mf));
            check("m_vc",     32'(umbral_vc_out), 32'(m_vc));
            check("m_d",      32'(umbral_d_out),  32'(m_d));
            check("m_mask",   32'(error_mask),    32'(m_mask));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        reset = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_idle",  32'(idle_out), 32'd0);
        check("rst_mask",  32'(error_mask), 32'd0);

        // All-zero thresholds never leave INIT
        init = 1'b1;
        tick(6);
        check("zero_init", 32'(init_out), 32'd1);
        check("zero_state", 32'(state), 32'd1);
        check("zero_mf", 32'(umbral_mf_out), 32'd0);

        umbral_mf = 4'd3;
        tick(1);
        check("cfg_mf", 32'(umbral_mf_out), 32'd3);
        check("cfg_idle", 32'(idle_out), 32'd1);
        check("cfg_vc", 32'(umbral_vc_out), 32'd0);
        init = 1'b0;

        // Activity then all-empty hold back to IDLE
        fifo_empties = 5'b11110;
        tick(1);
        check("act_enter", 32'(active_out), 32'd1);
        fifo_empties = '1;
        tick(3);
        check("hold_3", 32'(active_out), 32'd1);
        tick(1);
        check("hold_4", 32'(idle_out), 32'd1);

        // Non-empty at count 3 restarts the hold
        fifo_empties = 5'b11110;
        tick(1);
        fifo_empties = '1;
        tick(3);
        fifo_empties = 5'b11110;
        tick(1);
        check("restart_act", 32'(active_out), 32'd1);
        fifo_empties = '1;
        tick(3);
        check("restart_3", 32'(active_out), 32'd1);
        tick(1);
        check("restart_4", 32'(idle_out), 32'd1);

        // Reconfiguration in IDLE, ignored in ACTIVE
        init = 1'b1; umbral_vc = 4'd7;
        tick(1);
        check("recfg_vc", 32'(umbral_vc_out), 32'd7);
        check("recfg_state", 32'(state), 32'd2);
        init = 1'b0;
        fifo_empties = 5'b11110;
        tick(1);
        init = 1'b1; umbral_vc = 4'd2; umbral_d = 4'd5;
        tick(1);
        check("act_cfg_vc", 32'(umbral_vc_out), 32'd7);
        check("act_cfg_d", 32'(umbral_d_out), 32'd0);
        init = 1'b0;

        // Error capture and clear handshake
        fifo_errors = 5'b00100;
        tick(1);
        check("err_enter", 32'(error_out), 32'd1);
        fifo_errors = 5'b01000;
        tick(1);
        check("err_mask", 32'(error_mask), 32'h0c);
        error_clear = 1'b1;
        tick(1);
        check("err_hold", 32'(error_out), 32'd1);
        fifo_errors = '0;
        fifo_empties = '1;
        tick(1);
        check("clr_state", 32'(state), 32'd0);
        check("clr_mask", 32'(error_mask), 32'd0);
        check("clr_mf", 32'(umbral_mf_out), 32'd0);
        error_clear = 1'b0;
        tick(1);
        check("clr_init", 32'(init_out), 32'd1);

        // error_clear outside ERROR has no effect
        init = 1'b1; umbral_mf = 4'd1; umbral_vc = '0; umbral_d = '0;
        tick(1);
        init = 1'b0; error_clear = 1'b1;
        tick(1);
        check("clr_idle", 32'(idle_out), 32'd1);
        error_clear = 1'b0;

        // Error beats simultaneous hold expiry
        fifo_empties = 5'b11110;
        tick(1);
        fifo_empties = '1;
        tick(3);
        fifo_errors = 5'b00001;
        tick(1);
        check("simul_err", 32'(error_out), 32'd1);
        check("simul_idle", 32'(idle_out), 32'd0);
        check("simul_mask", 32'(error_mask), 32'd1);
        fifo_errors = '0; error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
        tick(1);
        init = 1'b1; umbral_mf = 4'd2;
        tick(1);
        init = 1'b0;

        // Error straight from IDLE
        fifo_errors = 5'b00010;
        tick(1);
        check("idle_err_mask", 32'(error_mask), 32'd2);
        fifo_errors = '0; error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
        tick(1);
        init = 1'b1;
        tick(1);
        init = 1'b0;

        // Reset mid-ACTIVE
        fifo_empties = 5'b11110;
        tick(1);
        check("pre_rst_act", 32'(active_out), 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_act", 32'(active_out), 32'd0);
        check("mid_rst_mf", 32'(umbral_mf_out), 32'd0);
        reset = 1'b0;
        fifo_empties = '1;
        tick(1);
        check("post_rst_init", 32'(init_out), 32'd1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
